rr_onehot_sel_gen: RTL and testbench

Round-robin one-hot select generator for the parameterised AND-array mux. Arbitrates among `WIDTH_I` request lines, drives a registered one-hot select vector `x` straight into the AND-array's `x` input, and holds it stable until the downstream consumer accepts it with a valid/ready handshake. Sits directly upstream of the AND-array mux. The mux's `in` data path is untouched.

---
 rtl/rr_onehot_sel_gen.sv | 155 +++++++++++++++
 tb/tb_rr_onehot_sel_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_sel_gen.sv
// Round-robin one-hot select generator feeding the AND-array mux select input.
// Optional forced release of unanswered grants is built when SEL_TIMEOUT_EN is defined.
module rr_onehot_sel_gen #(
  parameter int WIDTH_I = 2,
  parameter int TIMEOUT = 8,
  localparam int IDX_W = (WIDTH_I > 1) ? $clog2(WIDTH_I) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH_I-1:0] req,
  input  logic               ready,
  output logic [WIDTH_I-1:0] x,
  output logic               x_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state_r;
  logic [IDX_W-1:0]     ptr_r;
  logic [IDX_W-1:0]     grant_idx_r;
  logic [WIDTH_I-1:0]   x_r;
  logic                 x_valid_r;
  logic                 timeout_r;

  logic [IDX_W-1:0]     next_ptr_s;
  logic [IDX_W-1:0]     base_s;
  logic [IDX_W-1:0]     off_s;
  logic [IDX_W-1:0]     pick_s;
  logic [IDX_W:0]       sum_s;
  logic [2*WIDTH_I-1:0] dbl_s;
  logic [WIDTH_I-1:0]   rot_s;
  logic [WIDTH_I-1:0]   onehot_s;
  logic                 found_s;
  logic                 to_hit_s;
  logic                 release_s;

  if (WIDTH_I < 1 || TIMEOUT < 1) begin : g_param_check
    $fatal(1, "rr_onehot_sel_gen: WIDTH_I and TIMEOUT must both be >= 1");
  end

`ifdef SEL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_r;

  // Consecutive unanswered GRANT cycles; cleared while idle and on every release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (release_s || (state_r == IDLE)) begin
      cnt_r <= '0;
    end else if (!ready) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A ready arriving on the final count is a handshake, not a timeout.
  assign to_hit_s = (state_r == GRANT) && !ready && (cnt_r == CNT_W'(TIMEOUT - 1));
`else
  assign to_hit_s = 1'b0;
`endif

  assign release_s = (state_r == GRANT) && (ready || to_hit_s);

  // Rotate requests so the search base sits at bit 0, then take the lowest set bit.
  always_comb begin
    next_ptr_s = (grant_idx_r == IDX_W'(WIDTH_I - 1)) ? '0 : grant_idx_r + IDX_W'(1);
    if (state_r == GRANT) begin
      base_s = next_ptr_s;
    end else begin
      base_s = ptr_r;
    end
    dbl_s   = {req, req} >> base_s;
    rot_s   = dbl_s[WIDTH_I-1:0];
    found_s = 1'b0;
    off_s   = '0;
    for (int i = WIDTH_I - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        found_s = 1'b1;
        off_s   = IDX_W'(i);
      end else begin
        found_s = found_s;
      end
    end
    sum_s = {1'b0, base_s} + {1'b0, off_s};
    if (sum_s >= (IDX_W + 1)'(WIDTH_I)) begin
      pick_s = IDX_W'(sum_s - (IDX_W + 1)'(WIDTH_I));
    end else begin
      pick_s = sum_s[IDX_W-1:0];
    end
    onehot_s = '0;
    for (int i = 0; i < WIDTH_I; i++) begin
      onehot_s[i] = found_s && (pick_s == IDX_W'(i));
    end
  end

  // Grant FSM: load from IDLE, hold in GRANT until handshake or forced release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      x_r         <= '0;
      x_valid_r   <= 1'b0;
      grant_idx_r <= '0;
      timeout_r   <= 1'b0;
    end else begin
      timeout_r <= to_hit_s;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r     <= GRANT;
            x_r         <= onehot_s;
            x_valid_r   <= 1'b1;
            grant_idx_r <= pick_s;
          end else begin
            x_r       <= '0;
            x_valid_r <= 1'b0;
          end
        end
        GRANT: begin
          if (release_s) begin
            ptr_r <= next_ptr_s;
            if (found_s) begin
              x_r         <= onehot_s;
              x_valid_r   <= 1'b1;
              grant_idx_r <= pick_s;
            end else begin
              state_r     <= IDLE;
              x_r         <= '0;
              x_valid_r   <= 1'b0;
              grant_idx_r <= '0;
            end
          end else begin
            x_r <= x_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          x_r         <= '0;
          x_valid_r   <= 1'b0;
          grant_idx_r <= '0;
        end
      endcase
    end
  end

  assign x         = x_r;
  assign x_valid   = x_valid_r;
  assign grant_idx = grant_idx_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_onehot_sel_gen.sv
// Directed self-checking bench for rr_onehot_sel_gen: a 4-wide instance for arbitration
// and a 2-wide instance (TIMEOUT=3) for the forced-release behaviour.
module tb_rr_onehot_sel_gen;

  logic       clk;
  logic       rst_n;
  logic [3:0] req4;
  logic       ready4;
  logic [3:0] x4;
  logic       xv4;
  logic [1:0] gi4;
  logic       to4;
  logic [1:0] req2;
  logic       ready2;
  logic [1:0] x2;
  logic       xv2;
  logic [0:0] gi2;
  logic       to2;

  int checks;
  int failures;

  rr_onehot_sel_gen #(.WIDTH_I(4), .TIMEOUT(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .ready(ready4),
    .x(x4), .x_valid(xv4), .grant_idx(gi4), .timeout(to4)
  );

  rr_onehot_sel_gen #(.WIDTH_I(2), .TIMEOUT(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .ready(ready2),
    .x(x2), .x_valid(xv2), .grant_idx(gi2), .timeout(to2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [3:0] rot_exp [5];

  initial begin
    checks   = 0;
    failures = 0;
    rot_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n  = 1'b0;
    req4   = 4'b0000;
    ready4 = 1'b0;
    req2   = 2'b00;
    ready2 = 1'b0;
    step();
    step();
    chk("rst_x4", 32'(x4), 32'h0);
    chk("rst_xv4", 32'(xv4), 32'h0);
    chk("rst_gi4", 32'(gi4), 32'h0);
    chk("rst_to4", 32'(to4), 32'h0);
    chk("rst_x2", 32'(x2), 32'h0);
    rst_n = 1'b1;
    step();
    chk("idle_xv4", 32'(xv4), 32'h0);

    // single request, held with ready low, then accepted
    req4 = 4'b0010;
    step();
    chk("single_x", 32'(x4), 32'h2);
    chk("single_gi", 32'(gi4), 32'h1);
    chk("single_xv", 32'(xv4), 32'h1);
    req4 = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_hold", 32'(x4), 32'h2);
    end
    ready4 = 1'b1;
    step();
    chk("single_done_xv", 32'(xv4), 32'h0);
    chk("single_done_x", 32'(x4), 32'h0);
    ready4 = 1'b0;

    // rotation with all requesting and ready held high
    do_reset();
    req4   = 4'b1111;
    ready4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rotate_x", 32'(x4), 32'(rot_exp[i]));
      chk("rotate_xv", 32'(xv4), 32'h1);
    end

    // fairness and wrap: drive ptr to 3, then 1001 grants bit 3 then bit 0
    req4 = 4'b0100;
    step();
    chk("wrap_pre_x", 32'(x4), 32'h4);
    req4 = 4'b1001;
    step();
    chk("wrap_x3", 32'(x4), 32'h8);
    chk("wrap_gi3", 32'(gi4), 32'h3);
    step();
    chk("wrap_x0", 32'(x4), 32'h1);
    chk("wrap_gi0", 32'(gi4), 32'h0);
    ready4 = 1'b0;
    req4   = 4'b0000;

    // stability: grant frozen while req changes
    do_reset();
    req4 = 4'b0100;
    step();
    chk("stab_x", 32'(x4), 32'h4);
    chk("stab_gi", 32'(gi4), 32'h2);
    req4 = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stab_hold", 32'(x4), 32'h4);
    end
    ready4 = 1'b1;
    step();
    chk("stab_next_x", 32'(x4), 32'h1);
    chk("stab_next_gi", 32'(gi4), 32'h0);
    ready4 = 1'b0;
    req4   = 4'b0000;

    // asynchronous reset in the middle of a grant
    do_reset();
    req4 = 4'b0100;
    step();
    chk("async_pre_x", 32'(x4), 32'h4);
    req4  = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk("async_x", 32'(x4), 32'h0);
    chk("async_xv", 32'(xv4), 32'h0);
    chk("async_to", 32'(to4), 32'h0);
    chk("async_gi", 32'(gi4), 32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("async_idle_xv", 32'(xv4), 32'h0);
      chk("async_idle_x", 32'(x4), 32'h0);
    end

    // ready while idle is ignored; a later request still loads normally
    ready4 = 1'b1;
    step();
    chk("rdy_idle_xv", 32'(xv4), 32'h0);
    req4 = 4'b0001;
    step();
    chk("rdy_idle_x", 32'(x4), 32'h1);
    chk("rdy_idle_xv2", 32'(xv4), 32'h1);
    ready4 = 1'b0;
    req4   = 4'b0000;

    // forced release on the 2-wide instance
    req2   = 2'b11;
    ready2 = 1'b0;
    step();
    chk("to_grant_x", 32'(x2), 32'h1);
    chk("to_grant_to", 32'(to2), 32'h0);
    step();
    chk("to_hold1_x", 32'(x2), 32'h1);
    step();
    chk("to_hold2_x", 32'(x2), 32'h1);
    chk("to_hold2_to", 32'(to2), 32'h0);
    step();
`ifdef SEL_TIMEOUT_EN
    chk("to_fire_x", 32'(x2), 32'h2);
    chk("to_fire_gi", 32'(gi2), 32'h1);
    chk("to_fire_to", 32'(to2), 32'h1);
    step();
    chk("to_after_x", 32'(x2), 32'h2);
    chk("to_after_to", 32'(to2), 32'h0);
`else
    chk("nto_hold3_x", 32'(x2), 32'h1);
    chk("nto_hold3_to", 32'(to2), 32'h0);
    step();
    chk("nto_hold4_x", 32'(x2), 32'h1);
    chk("nto_hold4_to", 32'(to2), 32'h0);
`endif
    chk("to_xv2", 32'(xv2), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
